// File: rtl/lag_output_lock.sv
// lag_output_lock: packet-level output-port lock placed directly behind the tree arbiter.
// Optional forced release after a stall timeout is enabled by defining LAG_LOCK_TIMEOUT_EN.
module lag_output_lock #(
    parameter int SIZE    = 20,
    parameter int IDX_W   = $clog2(SIZE),
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SIZE-1:0]  i_req_in,
    output logic [SIZE-1:0]  o_arb_request,
    input  logic [SIZE-1:0]  i_arb_grant,
    output logic             o_arb_success,
    input  logic [SIZE-1:0]  i_flit_valid,
    input  logic [SIZE-1:0]  i_flit_tail,
    input  logic             i_out_ready,
    output logic             o_xbar_valid,
    output logic [IDX_W-1:0] o_xbar_sel,
    output logic [SIZE-1:0]  o_flit_pop,
    output logic             o_locked,
    output logic             o_timeout_evt
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [SIZE-1:0]  r_owner, w_owner_nxt, w_grant_oh;
    logic [IDX_W-1:0] r_sel, w_sel_nxt, w_grant_idx;
    logic             w_grant_any, w_fwd, w_owner_tail, w_timeout;

    assign w_grant_any  = |i_arb_grant;
    assign w_grant_oh   = SIZE'(1) << w_grant_idx;
    assign w_owner_tail = |(r_owner & i_flit_tail);
    assign w_fwd        = (r_state == LOCKED) && |(r_owner & i_flit_valid) && i_out_ready;

    // Binary index of the lowest set grant bit; a multi-hot grant collapses to its lowest input.
    always_comb begin
        w_grant_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (i_arb_grant[i]) w_grant_idx = IDX_W'(i);
    end

`ifdef LAG_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_idle_cnt;

    // Counts consecutive stalled LOCKED cycles, saturating rather than wrapping.
    always_ff @(posedge i_clk)
        if (i_rst || r_state == IDLE || w_fwd) r_idle_cnt <= '0;
        else if (r_idle_cnt != CNT_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;

    assign w_timeout = (r_state == LOCKED) && !w_fwd && (r_idle_cnt == CNT_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and outputs; everything is held at zero while reset is high.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_sel_nxt     = r_sel;
        o_arb_request = '0;
        o_arb_success = 1'b0;
        o_locked      = 1'b0;
        o_xbar_valid  = 1'b0;
        o_flit_pop    = '0;
        o_timeout_evt = 1'b0;
        o_xbar_sel    = i_rst ? '0 : r_sel;
        if (!i_rst) begin
            if (r_state == IDLE) begin
                o_arb_request = i_req_in;
                o_arb_success = w_grant_any;
                if (w_grant_any) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_grant_oh;
                    w_sel_nxt   = w_grant_idx;
                end
            end else begin
                o_locked      = 1'b1;
                o_xbar_valid  = w_fwd;
                o_flit_pop    = r_owner & {SIZE{w_fwd}};
                o_timeout_evt = w_timeout;
                if ((w_fwd && w_owner_tail) || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_owner_nxt = '0;
                end
            end
        end
    end

    // State register; xbar_sel keeps the last owner index after release.
    always_ff @(posedge i_clk)
        if (i_rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_sel   <= w_sel_nxt;
        end

    a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        r_state == IDLE |-> $onehot0(i_arb_grant));
    a_timeout_cfg: assert property (@(posedge i_clk) TIMEOUT > 0);
endmodule
